// File: rtl/symbol_packer.sv
// symbol_packer: pops SYM_W-bit symbols from a registered-empty queue and packs
// them LSB-first into WORD_SYMS-symbol words on a valid/ready port.
//   clk, rst (sync, active-high)
//   q_empty, q_dout  -> queue status/data in; q_dequeue -> pop request out
//   flush            -> pulse: emit the zero-padded partial word once drained
//   out_data/out_count/out_valid <- word port, out_ready -> consumer accept
//   busy             <- FSM not idle or symbols held
module symbol_packer #(
    parameter int SYM_W     = 2,
    parameter int WORD_SYMS = 4,
    localparam int DW       = SYM_W * WORD_SYMS,
    localparam int CW       = $clog2(WORD_SYMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          q_empty,
    input  logic [SYM_W-1:0] q_dout,
    output logic          q_dequeue,
    input  logic          flush,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] out_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(WORD_SYMS);

    state_t        state_q, state_d;
    logic [CW-1:0] sym_cnt_q, sym_cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          flush_pend_q, flush_pend_d;
    logic          q_dequeue_q, q_dequeue_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          handshake;

    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        data_d       = data_q;
        flush_pend_d = flush_pend_q;
        handshake    = out_valid_q && out_ready;

        unique case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    state_d = REQ;
                end else if (flush_pend_q && sym_cnt_q != '0) begin
                    state_d = OUT;
                end else if (flush_pend_q) begin
                    flush_pend_d = 1'b0;
                end
            end
            REQ: begin
                state_d = CAP;
            end
            CAP: begin
                // q_dout is valid now; empty is deliberately not re-checked.
                for (int k = 0; k < WORD_SYMS; k++) begin
                    if (sym_cnt_q == CW'(k)) begin
                        data_d[k*SYM_W +: SYM_W] = q_dout;
                    end
                end
                if (sym_cnt_q != FULL) begin
                    sym_cnt_d = sym_cnt_q + CW'(1);
                end
                state_d = (sym_cnt_d == FULL) ? OUT : IDLE;
            end
            OUT: begin
                if (handshake) begin
                    state_d   = IDLE;
                    sym_cnt_d = '0;
                    data_d    = '0;
                    if (sym_cnt_q < FULL || q_empty) begin
                        flush_pend_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new flush request wins over any clear in the same cycle.
        if (flush) begin
            flush_pend_d = 1'b1;
        end

        q_dequeue_d = (state_d == REQ);
        out_valid_d = (state_d == OUT);
        out_count_d = out_valid_d ? sym_cnt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sym_cnt_q    <= '0;
            data_q       <= '0;
            flush_pend_q <= 1'b0;
            q_dequeue_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            data_q       <= data_d;
            flush_pend_q <= flush_pend_d;
            q_dequeue_q  <= q_dequeue_d;
            out_valid_q  <= out_valid_d;
            out_count_q  <= out_count_d;
        end
    end

    assign q_dequeue = q_dequeue_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_count = out_count_q;
    assign busy      = (state_q != IDLE) || (sym_cnt_q != '0);

endmodule

// File: tb/tb_symbol_packer.sv
// tb_symbol_packer: queue model + word scoreboard for symbol_packer.
// Expected words are queued at stimulus time and popped on each handshake.
module tb_symbol_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       q_empty;
    logic [1:0] q_dout;
    logic       q_dequeue;
    logic       flush = 1'b0;
    logic [7:0] out_data;
    logic [2:0] out_count;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic       push_v = 1'b0;
    logic [1:0] push_d = '0;
    logic [1:0] fifo[$];
    logic [10:0] exp_q[$];
    int         deq_cnt = 0;
    int         adj_err = 0;
    logic       prev_deq = 1'b0;

    always #5 clk = ~clk;

    symbol_packer #(.SYM_W(2), .WORD_SYMS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .q_empty  (q_empty),
        .q_dout   (q_dout),
        .q_dequeue(q_dequeue),
        .flush    (flush),
        .out_data (out_data),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Queue model: Dout registered on a sampled dequeue, empty flag registered.
    always @(posedge clk) begin
        if (rst) begin
            fifo.delete();
            q_empty <= 1'b1;
            q_dout  <= '0;
        end else begin
            if (q_dequeue && fifo.size() > 0) begin
                q_dout <= fifo.pop_front();
            end
            if (push_v) begin
                fifo.push_back(push_d);
            end
            q_empty <= (fifo.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (q_dequeue) begin
            deq_cnt++;
            if (prev_deq) adj_err++;
        end
        prev_deq = q_dequeue;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'd0, out_data}, 32'hffff_ffff);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("word_data", {24'd0, out_data}, {24'd0, e[7:0]});
                check("word_count", {29'd0, out_count}, {29'd0, e[10:8]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] s);
        push_v = 1'b1;
        push_d = s;
        tick();
        push_v = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    function automatic logic [7:0] pack4(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c, input logic [1:0] d);
        return {d, c, b, a};
    endfunction

    initial begin
        logic [1:0] s[8];
        int d0;
        int n;

        repeat (3) tick();
        @(negedge clk);
        check("rst_deq", q_dequeue, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", out_count, 0);
        check("rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: one full word
        d0 = deq_cnt;
        exp_q.push_back({3'd4, 8'h39});
        enq(2'b01); enq(2'b10); enq(2'b11); enq(2'b00);
        wait_drain(100);
        check("t1_deq_pulses", deq_cnt - d0, 4);
        check("t1_adjacent", adj_err, 0);
        check("t1_busy", busy, 0);

        // 2: backpressure holds the word and stalls the queue
        out_ready = 1'b0;
        exp_q.push_back({3'd4, 8'h39});
        enq(2'b01); enq(2'b10); enq(2'b11); enq(2'b00);
        enq(2'b10);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t2_valid_timeout", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_data", out_data, 8'h39);
            check("t2_hold_count", out_count, 4);
            check("t2_no_deq", q_dequeue, 0);
        end
        tick();
        out_ready = 1'b1;
        wait_drain(100);
        exp_q.push_back({3'd1, 8'h02});
        pulse_flush();
        wait_drain(100);

        // 3: partial word via flush
        exp_q.push_back({3'd3, 8'h27});
        enq(2'b11); enq(2'b01); enq(2'b10);
        pulse_flush();
        wait_drain(100);
        check("t3_busy", busy, 0);
        check("t3_flush_pend", dut.flush_pend_q, 0);

        // 4: flush with nothing held
        pulse_flush();
        tick();
        @(negedge clk);
        check("t4_flush_pend", dut.flush_pend_q, 0);
        repeat (6) begin
            @(negedge clk);
            check("t4_no_valid", out_valid, 0);
        end
        tick();

        // 5: eight random symbols, two words in order
        for (int i = 0; i < 8; i++) s[i] = 2'($urandom_range(0, 3));
        exp_q.push_back({3'd4, pack4(s[0], s[1], s[2], s[3])});
        exp_q.push_back({3'd4, pack4(s[4], s[5], s[6], s[7])});
        for (int i = 0; i < 8; i++) enq(s[i]);
        wait_drain(200);
        check("t5_adjacent", adj_err, 0);

        // 6: reset while capturing the third symbol
        enq(2'b11); enq(2'b11); enq(2'b11); enq(2'b11);
        n = 0;
        @(negedge clk);
        while (!(int'(dut.state_q) == 2 && dut.sym_cnt_q == 3'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_cap_timeout", n < 100, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_deq", q_dequeue, 0);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_count", out_count, 0);
        check("t6_rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        exp_q.push_back({3'd4, pack4(2'b10, 2'b01, 2'b00, 2'b10)});
        enq(2'b10); enq(2'b01); enq(2'b00); enq(2'b10);
        wait_drain(100);
        check("t6_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
